// File: rtl/mem_port_arbiter.sv
// Arbitrates the MEM-stage data port and the IF-stage fetch port onto one shared memory port,
// with fetch-starvation protection and a per-access timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [2:0]  IF_RD_CTRL = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [2:0]  d_rd_ctrl,
  input  logic [2:0]  d_wr_ctrl,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_din,
  output logic [2:0]  mem_rd_ctrl,
  output logic [2:0]  mem_wr_ctrl,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [63:0] mem_dout,
  output logic        timeout_err
);

  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] WaitLast  = WW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StBusyD, StBusyI} state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic [WW-1:0] wait_q;

  logic d_ok, i_ok, starve_win, grant_d, grant_i, d_noop, idle;

  assign idle       = (state_q == StIdle);
  assign d_ok       = d_req & ~d_done;
  assign i_ok       = i_req & ~i_done;
  assign starve_win = (starve_q == StarveMax);
  assign d_noop     = (d_rd_ctrl == 3'd0) && (d_wr_ctrl == 3'd0);
  assign grant_d    = idle & d_ok & ~(i_ok & starve_win);
  // A data port that is masked only by its own done pulse keeps priority, so fetch gets in
  // ahead of a continuously requesting data port only through starvation.
  assign grant_i    = idle & i_ok & ~grant_d & (starve_win | ~d_req);

  assign d_stall = d_req & ~d_done;
  assign i_stall = i_req & ~i_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_rd_ctrl <= '0;
      mem_wr_ctrl <= '0;
      mem_valid   <= 1'b0;
      d_rdata     <= '0;
      i_rdata     <= '0;
      d_done      <= 1'b0;
      i_done      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      d_done <= 1'b0;
      i_done <= 1'b0;
      case (state_q)
        StIdle: begin
          wait_q <= '0;
          if (grant_d) begin
            starve_q <= !i_req ? '0 : (starve_win ? starve_q : starve_q + 1'b1);
            if (d_noop) begin
              d_done <= 1'b1;
            end else begin
              mem_addr    <= d_addr;
              mem_din     <= d_wdata;
              mem_wr_ctrl <= d_wr_ctrl;
              mem_rd_ctrl <= (d_wr_ctrl != 3'd0) ? 3'd0 : d_rd_ctrl;
              mem_valid   <= 1'b1;
              state_q     <= StBusyD;
            end
          end else if (grant_i) begin
            starve_q    <= '0;
            mem_addr    <= i_addr;
            mem_din     <= '0;
            mem_rd_ctrl <= IF_RD_CTRL;
            mem_wr_ctrl <= 3'd0;
            mem_valid   <= 1'b1;
            state_q     <= StBusyI;
          end else if (!i_req) begin
            starve_q <= '0;
          end
        end
        StBusyD, StBusyI: begin
          if (mem_ready || (wait_q == WaitLast)) begin
            // Without mem_ready this is a timeout abort: return zero data.
            if (state_q == StBusyD) begin
              d_rdata <= mem_ready ? mem_dout : '0;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= mem_ready ? mem_dout[31:0] : '0;
              i_done  <= 1'b1;
            end
            if (!mem_ready) timeout_err <= 1'b1;
            mem_valid   <= 1'b0;
            mem_rd_ctrl <= 3'd0;
            mem_wr_ctrl <= 3'd0;
            wait_q      <= '0;
            state_q     <= StIdle;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, i_req, mem_ready;
  logic [63:0] d_addr, d_wdata, i_addr, mem_dout;
  logic [2:0]  d_rd_ctrl, d_wr_ctrl;
  logic [63:0] d_rdata, mem_addr, mem_din;
  logic [31:0] i_rdata;
  logic        d_done, d_stall, i_done, i_stall, mem_valid, timeout_err;
  logic [2:0]  mem_rd_ctrl, mem_wr_ctrl;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_rd_ctrl(d_rd_ctrl),
    .d_wr_ctrl(d_wr_ctrl), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd_ctrl(mem_rd_ctrl),
    .mem_wr_ctrl(mem_wr_ctrl), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dout(mem_dout), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  byte got [10];
  byte exp_order [10];
  int  ndone;
  int  n;
  bit  seen_fetch;

  initial begin
    reset = 1'b0; d_req = 1'b0; i_req = 1'b0; mem_ready = 1'b0;
    d_addr = '0; d_wdata = '0; i_addr = '0; mem_dout = '0; d_rd_ctrl = '0; d_wr_ctrl = '0;
    exp_order = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Data load, mem_ready two cycles after mem_valid
    d_req = 1'b1; d_rd_ctrl = 3'd3; d_addr = 64'h100;
    tick();
    chk("load_valid", 64'(mem_valid), 64'd1);
    chk("load_addr", mem_addr, 64'h100);
    chk("load_rd_ctrl", 64'(mem_rd_ctrl), 64'd3);
    chk("load_stall", 64'(d_stall), 64'd1);
    tick();
    chk("load_addr_stable", mem_addr, 64'h100);
    mem_ready = 1'b1; mem_dout = 64'hDEADBEEF;
    tick();
    chk("load_done", 64'(d_done), 64'd1);
    chk("load_rdata", d_rdata, 64'hDEADBEEF);
    chk("load_valid_clr", 64'(mem_valid), 64'd0);
    chk("load_stall_done", 64'(d_stall), 64'd0);
    d_req = 1'b0; mem_ready = 1'b0; d_rd_ctrl = 3'd0;
    tick();
    chk("load_done_pulse", 64'(d_done), 64'd0);
    chk("load_rdata_hold", d_rdata, 64'hDEADBEEF);

    // Store; inputs change mid-flight must not leak onto the port
    d_req = 1'b1; d_wr_ctrl = 3'd3; d_rd_ctrl = 3'd2; d_wdata = 64'h55; d_addr = 64'h200;
    tick();
    chk("st_wr_ctrl", 64'(mem_wr_ctrl), 64'd3);
    chk("st_rd_ctrl", 64'(mem_rd_ctrl), 64'd0);
    chk("st_din", mem_din, 64'h55);
    d_addr = 64'h999; d_wdata = 64'hAA;
    tick();
    chk("st_addr_stable", mem_addr, 64'h200);
    chk("st_din_stable", mem_din, 64'h55);
    mem_ready = 1'b1; mem_dout = 64'h1234;
    tick();
    chk("st_done", 64'(d_done), 64'd1);
    chk("st_rdata", d_rdata, 64'h1234);
    d_req = 1'b0; mem_ready = 1'b0; d_wr_ctrl = 3'd0; d_rd_ctrl = 3'd0;
    tick();

    // No-op data request never touches memory
    d_req = 1'b1;
    tick();
    chk("noop_done", 64'(d_done), 64'd1);
    chk("noop_valid", 64'(mem_valid), 64'd0);
    chk("noop_rdata", d_rdata, 64'h1234);
    d_req = 1'b0;
    tick();
    chk("noop_done_pulse", 64'(d_done), 64'd0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1; mem_dout = 64'hFFFF;
    tick(); tick();
    chk("idle_ready_done", 64'(d_done | i_done), 64'd0);
    chk("idle_ready_rdata", d_rdata, 64'h1234);

    // Both ports requesting continuously with mem_ready high
    mem_dout = 64'hCAFEF00D_12345678;
    d_req = 1'b1; d_rd_ctrl = 3'd3; d_addr = 64'h300; d_wdata = 64'h77;
    i_req = 1'b1; i_addr = 64'h4000;
    ndone = 0; seen_fetch = 1'b0;
    for (int c = 0; c < 80 && ndone < 10; c++) begin
      tick();
      if (mem_valid && mem_addr == 64'h4000 && !seen_fetch) begin
        seen_fetch = 1'b1;
        chk("fetch_rd_ctrl", 64'(mem_rd_ctrl), 64'd3);
        chk("fetch_din", mem_din, 64'd0);
      end
      if (d_done) begin got[ndone] = "D"; ndone++; end
      else if (i_done) begin got[ndone] = "I"; ndone++; end
    end
    d_req = 1'b0; i_req = 1'b0;
    chk("fetch_seen", 64'(seen_fetch), 64'd1);
    for (int k = 0; k < 10; k++) chk($sformatf("order%0d", k), 64'(got[k]), 64'(exp_order[k]));
    chk("arb_i_rdata", 64'(i_rdata), 64'h12345678);
    chk("arb_d_rdata", d_rdata, 64'hCAFEF00D_12345678);
    tick();

    // Timeout with mem_ready held low
    mem_ready = 1'b0;
    d_req = 1'b1; d_rd_ctrl = 3'd3; d_addr = 64'h500;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      n++;
      if (d_done) break;
    end
    chk("to_cycles", 64'(n), 64'd256);
    chk("to_rdata", d_rdata, 64'd0);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_valid", 64'(mem_valid), 64'd0);
    d_req = 1'b0; d_rd_ctrl = 3'd0;
    tick();
    chk("to_err_sticky", 64'(timeout_err), 64'd1);

    // Reset in the middle of a fetch
    i_req = 1'b1; i_addr = 64'h8000;
    tick();
    chk("rb_valid", 64'(mem_valid), 64'd1);
    chk("rb_addr", mem_addr, 64'h8000);
    #2 reset = 1'b0;
    #1;
    chk("rb_async_valid", 64'(mem_valid), 64'd0);
    chk("rb_async_err", 64'(timeout_err), 64'd0);
    chk("rb_async_addr", mem_addr, 64'd0);
    mem_ready = 1'b1; mem_dout = 64'hABCD;
    tick(); tick();
    chk("rb_no_done", 64'(i_done), 64'd0);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rb_no_early_grant", 64'(mem_valid), 64'd0);
    tick();
    chk("rb_regrant", 64'(mem_valid), 64'd1);
    chk("rb_regrant_addr", mem_addr, 64'h8000);
    mem_ready = 1'b1;
    tick();
    chk("rb_i_done", 64'(i_done), 64'd1);
    chk("rb_i_rdata", 64'(i_rdata), 64'hABCD);
    i_req = 1'b0; mem_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles a memory access may wait for mem_ready.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch is pending.
REQ-003 SHALL have parameter IF_RD_CTRL, default 3'd3: read-control code driven for instruction fetches.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port d_req  input  1  MEM-stage data request, held until d_done.
REQ-007 SHALL have port d_addr  input  64  data address.
REQ-008 SHALL have port d_wdata  input  64  store data.
REQ-009 SHALL have ports d_rd_ctrl / d_wr_ctrl  input  3 each  load/store type; 0 = none.
REQ-010 SHALL have ports d_rdata  output  64  load data; d_done  output  1  completion pulse; d_stall  output  1  stall MEM stage.
REQ-011 SHALL have port i_req  input  1  fetch request, held until i_done.
REQ-012 SHALL have port i_addr  input  64  fetch address.
REQ-013 SHALL have ports i_rdata  output  32  instruction; i_done  output  1  completion pulse; i_stall  output  1  stall IF stage.
REQ-014 SHALL have ports mem_addr  output  64; mem_din  output  64; mem_rd_ctrl  output  3; mem_wr_ctrl  output  3: shared memory port.
REQ-015 SHALL have ports mem_valid  output  1  access in flight; mem_ready  input  1  memory completes access; mem_dout  input  64  read data.
REQ-016 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_D, BUSY_I; transitions only on rising clk.
REQ-018 In IDLE, a port whose done is high in the current cycle SHALL be masked from arbitration.
REQ-019 In IDLE, priority SHALL be data over fetch, except fetch wins when starve counter == STARVE_MAX and i_req is high.
REQ-020 Starve counter SHALL increment on each data grant while i_req is high, saturate at STARVE_MAX, and clear on a fetch grant or when i_req is low in IDLE.
REQ-021 On a data grant: mem_addr<=d_addr, mem_din<=d_wdata, mem_wr_ctrl<=d_wr_ctrl, mem_rd_ctrl<=(d_wr_ctrl!=0 ? 0 : d_rd_ctrl), mem_valid<=1, go to BUSY_D.
REQ-022 On a fetch grant: mem_addr<=i_addr, mem_din<=0, mem_rd_ctrl<=IF_RD_CTRL, mem_wr_ctrl<=0, mem_valid<=1, go to BUSY_I.
REQ-023 Data request with d_rd_ctrl==0 and d_wr_ctrl==0 SHALL not touch memory: d_done pulses the cycle after grant, d_rdata unchanged, state stays IDLE.
REQ-024 In BUSY_x with mem_ready high at an edge: capture mem_dout (d_rdata<=mem_dout, or i_rdata<=mem_dout[31:0]), pulse that port's done for exactly one cycle, clear mem_valid/mem_rd_ctrl/mem_wr_ctrl, return to IDLE.
REQ-025 Minimum latency SHALL be: grant edge N, mem_ready sampled edge N+1, done high in cycle after N+1; no new grant on edge N+2 for same port (REQ-018).
REQ-026 mem_addr/mem_din/ctrl SHALL remain stable while mem_valid is high.
REQ-027 Wait counter SHALL count edges in BUSY_x; on reaching TIMEOUT without mem_ready: abort, pulse done with rdata forced 0, set timeout_err, return to IDLE.
REQ-028 mem_ready high while IDLE SHALL be ignored.
REQ-029 d_stall SHALL equal d_req & ~d_done; i_stall SHALL equal i_req & ~i_done (combinational).
REQ-030 Input changes on a port while it is in BUSY SHALL not affect the in-flight access.

Reset
REQ-031 reset low SHALL immediately force state IDLE, all counters 0, and every registered output (mem_*, d_rdata, i_rdata, d_done, i_done, timeout_err) to 0, including mid-transaction.
REQ-032 After reset release, first grant SHALL occur no earlier than the first rising edge with reset high.

Verification
REQ-033 Data load: d_req=1, d_rd_ctrl=3, d_addr=0x100, mem_ready 2 cycles after mem_valid, mem_dout=0xDEADBEEF -> d_rdata=0xDEADBEEF, single-cycle d_done, d_stall low after.
REQ-034 Simultaneous d_req and i_req held continuously, mem_ready=1 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 Store: d_wr_ctrl=3, d_rd_ctrl=2, d_wdata=0x55 -> mem_wr_ctrl=3, mem_rd_ctrl=0, mem_din=0x55 while mem_valid.
REQ-036 mem_ready held 0 -> done pulse after 255 BUSY edges, rdata=0, timeout_err=1 until reset.
REQ-037 reset asserted in BUSY_I -> mem_valid=0 without clock edge, no i_done, next fetch re-granted after release.
REQ-038 No-op data request (both ctrl 0) -> d_done next cycle, mem_valid never asserted.
